// File: rtl/cpunc_axi_mem_slave.sv
// cpunc_axi_mem_slave: single-beat AXI responder backed by a local word memory.
// Independent read and write FSMs, one outstanding transaction each.
// Optional macro CPUNC_MEM_WAIT_EN inserts 3 wait cycles before BVALID/RVALID.
`timescale 1ns/1ps
module cpunc_axi_mem_slave #(
  parameter int MEM_POWER_SIZE = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = MEM_POWER_SIZE,
  parameter int AXI_MASK_WIDTH = AXI_DATA_WIDTH/8
) (
  input  logic                      CPUNC_ACLK,
  input  logic                      CPUNC_ARESETn,
  input  logic [7:0]                CPUNC_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_AWADDR,
  input  logic [7:0]                CPUNC_AWLN,
  input  logic [1:0]                CPUNC_AWSIZE,
  input  logic [1:0]                CPUNC_AWBURST,
  input  logic                      CPUNC_AWLOCK,
  input  logic [2:0]                CPUNC_AWCACHE,
  input  logic                      CPUNC_AWPROT,
  input  logic [2:0]                CPUNC_AWQOS,
  input  logic                      CPUNC_AWVALID,
  output logic                      CPUNC_AWREADY,
  input  logic [7:0]                CPUNC_WID,
  input  logic [AXI_DATA_WIDTH-1:0] CPUNC_WDATA,
  input  logic [AXI_MASK_WIDTH-1:0] CPUNC_WSTRB,
  input  logic                      CPUNC_WLAST,
  input  logic                      CPUNC_WVALID,
  output logic                      CPUNC_WREADY,
  output logic [7:0]                CPUNC_BID,
  output logic                      CPUNC_BRESP,
  output logic                      CPUNC_BVALID,
  input  logic                      CPUNC_BREADY,
  input  logic [7:0]                CPUNC_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_ARADDR,
  input  logic [7:0]                CPUNC_ARLN,
  input  logic [1:0]                CPUNC_ARSIZE,
  input  logic [1:0]                CPUNC_ARBURST,
  input  logic                      CPUNC_ARLOCK,
  input  logic [2:0]                CPUNC_ARCACHE,
  input  logic                      CPUNC_ARPROT,
  input  logic [2:0]                CPUNC_ARQOS,
  input  logic                      CPUNC_ARVALID,
  output logic                      CPUNC_ARREADY,
  output logic [7:0]                CPUNC_RID,
  output logic [AXI_DATA_WIDTH-1:0] CPUNC_RDATA,
  output logic                      CPUNC_RRESP,
  output logic                      CPUNC_RLAST,
  output logic                      CPUNC_RVALID,
  input  logic                      CPUNC_RREADY
);
  localparam int IDX_W = MEM_POWER_SIZE - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wst_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_WAIT, R_RESP} rst_e;

  wst_e w_state_q, w_state_d;
  rst_e r_state_q, r_state_d;
  logic [7:0]       w_id_q, w_id_d, r_id_q, r_id_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d, r_idx_q, r_idx_d;
  logic             w_err_q, w_err_d, r_err_q, r_err_d;
`ifdef CPUNC_MEM_WAIT_EN
  logic [1:0]       wcnt_q, wcnt_d, rcnt_q, rcnt_d;
`endif

  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, bresp_q, bresp_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rresp_q, rresp_d, rlast_q, rlast_d;
  logic [7:0] bid_q, bid_d, rid_q, rid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic mem_we;

  // Attribute inputs are accepted but carry no meaning for this target.
  logic unused_ok;
  assign unused_ok = ^{CPUNC_AWSIZE, CPUNC_AWBURST, CPUNC_AWLOCK, CPUNC_AWCACHE, CPUNC_AWPROT,
                       CPUNC_AWQOS, CPUNC_ARSIZE, CPUNC_ARBURST, CPUNC_ARLOCK, CPUNC_ARCACHE,
                       CPUNC_ARPROT, CPUNC_ARQOS, CPUNC_WID, CPUNC_AWADDR[1:0], CPUNC_ARADDR[1:0]};

  // State, captured request fields and registered outputs.
  always_ff @(posedge CPUNC_ACLK or negedge CPUNC_ARESETn) begin
    if (!CPUNC_ARESETn) begin
      w_state_q <= W_IDLE; r_state_q <= R_IDLE;
      w_id_q <= '0; w_idx_q <= '0; w_err_q <= 1'b0;
      r_id_q <= '0; r_idx_q <= '0; r_err_q <= 1'b0;
`ifdef CPUNC_MEM_WAIT_EN
      wcnt_q <= '0; rcnt_q <= '0;
`endif
      awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= 1'b0; bid_q <= '0;
      arready_q <= 1'b0; rvalid_q <= 1'b0; rresp_q <= 1'b0; rlast_q <= 1'b0; rid_q <= '0;
      rdata_q <= '0;
    end else begin
      w_state_q <= w_state_d; r_state_q <= r_state_d;
      w_id_q <= w_id_d; w_idx_q <= w_idx_d; w_err_q <= w_err_d;
      r_id_q <= r_id_d; r_idx_q <= r_idx_d; r_err_q <= r_err_d;
`ifdef CPUNC_MEM_WAIT_EN
      wcnt_q <= wcnt_d; rcnt_q <= rcnt_d;
`endif
      awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d; bresp_q <= bresp_d;
      bid_q <= bid_d;
      arready_q <= arready_d; rvalid_q <= rvalid_d; rresp_q <= rresp_d; rlast_q <= rlast_d;
      rid_q <= rid_d; rdata_q <= rdata_d;
    end
  end

  // Write FSM next state; handshakes qualified by the registered READY/VALID.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_err_d   = w_err_q;
`ifdef CPUNC_MEM_WAIT_EN
    wcnt_d    = wcnt_q;
`endif
    unique case (w_state_q)
      W_IDLE: if (awready_q && CPUNC_AWVALID) begin
        w_id_d    = CPUNC_AWID;
        w_idx_d   = CPUNC_AWADDR[MEM_POWER_SIZE-1:2];
        w_err_d   = (CPUNC_AWLN != 8'd0);
        w_state_d = W_DATA;
      end
      W_DATA: if (wready_q && CPUNC_WVALID) begin
        w_err_d = w_err_q | ~CPUNC_WLAST;
`ifdef CPUNC_MEM_WAIT_EN
        wcnt_d    = 2'd3;
        w_state_d = W_WAIT;
`else
        w_state_d = W_RESP;
`endif
      end
      W_WAIT: begin
`ifdef CPUNC_MEM_WAIT_EN
        if (wcnt_q == 2'd1) w_state_d = W_RESP;
        wcnt_d = wcnt_q - 2'd1;
`else
        w_state_d = W_IDLE;
`endif
      end
      W_RESP: if (bvalid_q && CPUNC_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state; the array is sampled on the R_FETCH edge.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_err_d   = r_err_q;
`ifdef CPUNC_MEM_WAIT_EN
    rcnt_d    = rcnt_q;
`endif
    unique case (r_state_q)
      R_IDLE: if (arready_q && CPUNC_ARVALID) begin
        r_id_d    = CPUNC_ARID;
        r_idx_d   = CPUNC_ARADDR[MEM_POWER_SIZE-1:2];
        r_err_d   = (CPUNC_ARLN != 8'd0);
        r_state_d = R_FETCH;
      end
      R_FETCH: begin
`ifdef CPUNC_MEM_WAIT_EN
        rcnt_d    = 2'd3;
        r_state_d = R_WAIT;
`else
        r_state_d = R_RESP;
`endif
      end
      R_WAIT: begin
`ifdef CPUNC_MEM_WAIT_EN
        if (rcnt_q == 2'd1) r_state_d = R_RESP;
        rcnt_d = rcnt_q - 2'd1;
`else
        r_state_d = R_IDLE;
`endif
      end
      R_RESP: if (rvalid_q && CPUNC_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Output next values derived from next state so every output is a flop.
  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    if (w_state_d == W_RESP && w_state_q != W_RESP) begin
      bid_d   = w_id_q;
      bresp_d = w_err_d;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
    rlast_d   = (r_state_d == R_RESP);
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (r_state_q == R_FETCH) begin
      rid_d   = r_id_q;
      rresp_d = r_err_q;
      rdata_d = r_err_q ? '0 : mem_q[r_idx_q];
    end
  end

  assign mem_we = (w_state_q == W_DATA) && wready_q && CPUNC_WVALID && !w_err_q && CPUNC_WLAST;

  // Byte-lane writes; memory is intentionally left unreset.
  always_ff @(posedge CPUNC_ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < AXI_MASK_WIDTH; i++)
        if (CPUNC_WSTRB[i]) mem_q[w_idx_q][i*8 +: 8] <= CPUNC_WDATA[i*8 +: 8];
    end
  end

  assign CPUNC_AWREADY = awready_q;
  assign CPUNC_WREADY  = wready_q;
  assign CPUNC_BVALID  = bvalid_q;
  assign CPUNC_BRESP   = bresp_q;
  assign CPUNC_BID     = bid_q;
  assign CPUNC_ARREADY = arready_q;
  assign CPUNC_RVALID  = rvalid_q;
  assign CPUNC_RRESP   = rresp_q;
  assign CPUNC_RLAST   = rlast_q;
  assign CPUNC_RID     = rid_q;
  assign CPUNC_RDATA   = rdata_q;
endmodule

// File: tb/tb_cpunc_axi_mem_slave.sv
// Directed bench for cpunc_axi_mem_slave: writes with strobes, error responses,
// response back-pressure, concurrent read/write, and mid-transaction reset.
`timescale 1ns/1ps
module tb_cpunc_axi_mem_slave;
`ifdef CPUNC_MEM_WAIT_EN
  localparam int WAITC = 3;
`else
  localparam int WAITC = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] awid = '0, awln = '0, wid = '0, arid = '0, arln = '0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bresp, bvalid, arready, rresp, rlast, rvalid;
  logic [7:0] bid, rid;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpunc_axi_mem_slave dut (
    .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst_n),
    .CPUNC_AWID(awid), .CPUNC_AWADDR(awaddr), .CPUNC_AWLN(awln),
    .CPUNC_AWSIZE(2'd2), .CPUNC_AWBURST(2'd1), .CPUNC_AWLOCK(1'b0), .CPUNC_AWCACHE(3'd0),
    .CPUNC_AWPROT(1'b0), .CPUNC_AWQOS(3'd0), .CPUNC_AWVALID(awvalid), .CPUNC_AWREADY(awready),
    .CPUNC_WID(wid), .CPUNC_WDATA(wdata), .CPUNC_WSTRB(wstrb), .CPUNC_WLAST(wlast),
    .CPUNC_WVALID(wvalid), .CPUNC_WREADY(wready),
    .CPUNC_BID(bid), .CPUNC_BRESP(bresp), .CPUNC_BVALID(bvalid), .CPUNC_BREADY(bready),
    .CPUNC_ARID(arid), .CPUNC_ARADDR(araddr), .CPUNC_ARLN(arln),
    .CPUNC_ARSIZE(2'd2), .CPUNC_ARBURST(2'd1), .CPUNC_ARLOCK(1'b0), .CPUNC_ARCACHE(3'd0),
    .CPUNC_ARPROT(1'b0), .CPUNC_ARQOS(3'd0), .CPUNC_ARVALID(arvalid), .CPUNC_ARREADY(arready),
    .CPUNC_RID(rid), .CPUNC_RDATA(rdata), .CPUNC_RRESP(rresp), .CPUNC_RLAST(rlast),
    .CPUNC_RVALID(rvalid), .CPUNC_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'h0);
    chk({tag, "_wready"},  32'(wready),  32'h0);
    chk({tag, "_bvalid"},  32'(bvalid),  32'h0);
    chk({tag, "_bresp"},   32'(bresp),   32'h0);
    chk({tag, "_bid"},     32'(bid),     32'h0);
    chk({tag, "_arready"}, 32'(arready), 32'h0);
    chk({tag, "_rvalid"},  32'(rvalid),  32'h0);
    chk({tag, "_rresp"},   32'(rresp),   32'h0);
    chk({tag, "_rlast"},   32'(rlast),   32'h0);
    chk({tag, "_rid"},     32'(rid),     32'h0);
    chk({tag, "_rdata"},   rdata,        32'h0);
  endtask

  task automatic wr(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] ln,
                    input logic [31:0] data, input logic [3:0] strb, input logic last,
                    input logic exp_resp, input int stall);
    int n = 0;
    awid = id; awaddr = addr; awln = ln; awvalid = 1'b1;
    while (!awready && n < 20) begin step(); n++; end
    chk("aw_ready_wait", 32'(awready), 32'h1);
    step(); awvalid = 1'b0;
    chk("aw_ready_drop", 32'(awready), 32'h0);
    chk("w_ready_up",    32'(wready),  32'h1);
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    step(); wvalid = 1'b0;
    chk("w_ready_drop", 32'(wready), 32'h0);
    for (int i = 0; i < WAITC; i++) begin chk("b_wait", 32'(bvalid), 32'h0); step(); end
    chk("b_valid", 32'(bvalid), 32'h1);
    chk("b_id",    32'(bid),    32'(id));
    chk("b_resp",  32'(bresp),  32'(exp_resp));
    for (int i = 0; i < stall; i++) begin
      step();
      chk("b_stall_valid", 32'(bvalid),  32'h1);
      chk("b_stall_id",    32'(bid),     32'(id));
      chk("b_stall_resp",  32'(bresp),   32'(exp_resp));
      chk("b_stall_awrdy", 32'(awready), 32'h0);
    end
    bready = 1'b1;
    step(); bready = 1'b0;
    chk("b_valid_drop", 32'(bvalid),  32'h0);
    chk("aw_ready_back", 32'(awready), 32'h1);
  endtask

  task automatic rd(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] ln,
                    input logic [31:0] exp_data, input logic exp_resp, input int stall);
    int n = 0;
    arid = id; araddr = addr; arln = ln; arvalid = 1'b1;
    while (!arready && n < 20) begin step(); n++; end
    chk("ar_ready_wait", 32'(arready), 32'h1);
    step(); arvalid = 1'b0;
    chk("ar_ready_drop", 32'(arready), 32'h0);
    chk("r_fetch_novalid", 32'(rvalid), 32'h0);
    step();
    for (int i = 0; i < WAITC; i++) begin chk("r_wait", 32'(rvalid), 32'h0); step(); end
    chk("r_valid", 32'(rvalid), 32'h1);
    chk("r_data",  rdata,       exp_data);
    chk("r_resp",  32'(rresp),  32'(exp_resp));
    chk("r_last",  32'(rlast),  32'h1);
    chk("r_id",    32'(rid),    32'(id));
    for (int i = 0; i < stall; i++) begin
      step();
      chk("r_stall_valid", 32'(rvalid),  32'h1);
      chk("r_stall_data",  rdata,        exp_data);
      chk("r_stall_id",    32'(rid),     32'(id));
      chk("r_stall_resp",  32'(rresp),   32'(exp_resp));
      chk("r_stall_arrdy", 32'(arready), 32'h0);
    end
    rready = 1'b1;
    step(); rready = 1'b0;
    chk("r_valid_drop",  32'(rvalid),  32'h0);
    chk("ar_ready_back", 32'(arready), 32'h1);
  endtask

  initial begin
    // Reset and READY rise on the first edge after release
    repeat (3) step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk("aw_ready_pre_edge", 32'(awready), 32'h0);
    step();
    chk("aw_ready_post_rst", 32'(awready), 32'h1);
    chk("ar_ready_post_rst", 32'(arready), 32'h1);

    // Full word write then readback
    wr(8'h11, 12'h010, 8'd0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 0);
    rd(8'h21, 12'h010, 8'd0, 32'hDEADBEEF, 1'b0, 0);

    // Byte strobe merge, then an all-off strobe leaves the word alone
    wr(8'h12, 12'h010, 8'd0, 32'h000000AA, 4'h1, 1'b1, 1'b0, 0);
    rd(8'h22, 12'h010, 8'd0, 32'hDEADBEAA, 1'b0, 0);
    wr(8'h13, 12'h010, 8'd0, 32'h11223344, 4'h0, 1'b1, 1'b0, 0);
    rd(8'h23, 12'h010, 8'd0, 32'hDEADBEAA, 1'b0, 0);

    // Middle-lane strobes
    wr(8'h14, 12'h014, 8'd0, 32'h00000000, 4'hF, 1'b1, 1'b0, 0);
    wr(8'h15, 12'h014, 8'd0, 32'h44332211, 4'h6, 1'b1, 1'b0, 0);
    rd(8'h24, 12'h014, 8'd0, 32'h00332200, 1'b0, 0);

    // Burst requests get error responses and do not touch memory
    wr(8'h5A, 12'h010, 8'd1, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 0);
    rd(8'h25, 12'h010, 8'd0, 32'hDEADBEAA, 1'b0, 0);
    rd(8'h26, 12'h010, 8'd3, 32'h00000000, 1'b1, 0);
    // Missing WLAST is an error too
    wr(8'h16, 12'h010, 8'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 0);
    rd(8'h27, 12'h010, 8'd0, 32'hDEADBEAA, 1'b0, 0);

    // Response back-pressure for 5 cycles
    wr(8'h17, 12'h030, 8'd0, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, 5);
    rd(8'h28, 12'h030, 8'd0, 32'h0BADF00D, 1'b0, 5);

    // Concurrent read and write issued on the same cycle
    wr(8'h18, 12'h020, 8'd0, 32'h12345678, 4'hF, 1'b1, 1'b0, 0);
    fork
      wr(8'h19, 12'h024, 8'd0, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 0);
      rd(8'h29, 12'h020, 8'd0, 32'h12345678, 1'b0, 0);
    join
    rd(8'h2A, 12'h024, 8'd0, 32'hCAFEF00D, 1'b0, 0);

    // Reset while the write sits in W_DATA
    awid = 8'h33; awaddr = 12'h010; awln = 8'd0; awvalid = 1'b1;
    step(); awvalid = 1'b0;
    chk("mid_w_data", 32'(wready), 32'h1);
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    step(); step();
    wvalid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("aw_ready_recover", 32'(awready), 32'h1);
    rd(8'h2B, 12'h010, 8'd0, 32'hDEADBEAA, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
